// File: rtl/dfa_seq_ctrl.sv
// Serialises one request string per transaction, MSB-first, into an external single-bit DFA,
// then returns the DFA verdict and keeps saturating accept/total statistics.
module dfa_seq_ctrl #(
   parameter int MAXLEN = 16,
   parameter int LEN_W  = $clog2(MAXLEN + 1),
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [MAXLEN-1:0] req_bits,
   input  logic [LEN_W-1:0]  req_len,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_accept,
   output logic              res_len_err,
   output logic              dfa_rst,
   output logic              dfa_in,
   input  logic              dfa_accept,
   output logic              busy,
   output logic [STAT_W-1:0] acc_cnt,
   output logic [STAT_W-1:0] tot_cnt
);

   localparam int IDX_W = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

   typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, CHECK, DONE} state_t;

   state_t              state_q, state_d;
   logic [MAXLEN-1:0]   bits_q, bits_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic                len_err_q, len_err_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                res_valid_q, res_valid_d;
   logic                res_accept_q, res_accept_d;
   logic                res_len_err_q, res_len_err_d;
   logic [STAT_W-1:0]   acc_cnt_q, acc_cnt_d;
   logic [STAT_W-1:0]   tot_cnt_q, tot_cnt_d;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         bits_q        <= '0;
         len_q         <= '0;
         len_err_q     <= 1'b0;
         idx_q         <= '0;
         res_valid_q   <= 1'b0;
         res_accept_q  <= 1'b0;
         res_len_err_q <= 1'b0;
         acc_cnt_q     <= '0;
         tot_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         bits_q        <= bits_d;
         len_q         <= len_d;
         len_err_q     <= len_err_d;
         idx_q         <= idx_d;
         res_valid_q   <= res_valid_d;
         res_accept_q  <= res_accept_d;
         res_len_err_q <= res_len_err_d;
         acc_cnt_q     <= acc_cnt_d;
         tot_cnt_q     <= tot_cnt_d;
      end
   end

   // NOTE: every signal gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d       = state_q;
      bits_d        = bits_q;
      len_d         = len_q;
      len_err_d     = len_err_q;
      idx_d         = idx_q;
      res_valid_d   = res_valid_q;
      res_accept_d  = res_accept_q;
      res_len_err_d = res_len_err_q;
      acc_cnt_d     = acc_cnt_q;
      tot_cnt_d     = tot_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               bits_d    = req_bits;
               len_err_d = (req_len > LEN_W'(MAXLEN));
               len_d     = len_err_d ? LEN_W'(MAXLEN) : req_len;
               state_d   = CLEAR;
            end
         end
         CLEAR: begin
            // For the empty string the index value is never used.
            idx_d   = IDX_W'(len_q - LEN_W'(1));
            state_d = (len_q != '0) ? SHIFT : CHECK;
         end
         SHIFT: begin
            if (idx_q == '0) state_d = CHECK;
            else             idx_d   = idx_q - IDX_W'(1);
         end
         CHECK: begin
            res_accept_d  = dfa_accept;
            res_len_err_d = len_err_q;
            res_valid_d   = 1'b1;
            if (tot_cnt_q != '1)               tot_cnt_d = tot_cnt_q + STAT_W'(1);
            if (dfa_accept && acc_cnt_q != '1) acc_cnt_d = acc_cnt_q + STAT_W'(1);
            state_d = DONE;
         end
         DONE: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready   = (state_q == IDLE);
      busy        = (state_q != IDLE);
      dfa_rst     = ~rst | (state_q == CLEAR);
      dfa_in      = (state_q == SHIFT) ? bits_q[idx_q] : 1'b0;
      res_valid   = res_valid_q;
      res_accept  = res_accept_q;
      res_len_err = res_len_err_q;
      acc_cnt     = acc_cnt_q;
      tot_cnt     = tot_cnt_q;
   end

endmodule

// File: doc/dfa_seq_ctrl.md
Name: dfa_seq_ctrl

Overview:
- Sequencer that runs one binary string per request through an external single-bit DFA recognizer, such as ends-with-0, and returns its accept verdict.
- Per request it clears the DFA, serializes the string MSB-first into the DFA input one bit per clock, then samples the DFA accept output.
- Sits between a word-level requester (test driver or host) and any clk/rst/in/accept DFA in the fsm/dfa family.
- Keeps saturating statistics counters.

Parameters:
- MAXLEN, 16: maximum string length in bits; req_bits width.
- LEN_W, $clog2(MAXLEN+1): width of the length fields.
- STAT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_bits  in  MAXLEN  string; bit req_len-1 is sent first, bit 0 last.
- req_len  in  LEN_W  string length, 0..MAXLEN.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_accept  out  1  DFA verdict for the string.
- res_len_err  out  1  request had req_len > MAXLEN; length was clamped.
- dfa_rst  out  1  active-high reset to the DFA.
- dfa_in  out  1  serial bit to the DFA.
- dfa_accept  in  1  DFA accept output, Moore/registered.
- busy  out  1  high in every state except IDLE.
- acc_cnt  out  STAT_W  number of accepted strings.
- tot_cnt  out  STAT_W  number of strings processed.

Behaviour:
- Reset (rst low, asynchronous): state = IDLE; res_valid, res_accept, res_len_err, dfa_in, busy, acc_cnt and tot_cnt all 0; req_ready = 1.
- dfa_rst = (~rst) | (state == CLEAR). The DFA is therefore held in reset while rst is low.
- Five states: IDLE, CLEAR, SHIFT, CHECK, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch req_bits; latch len = min(req_len, MAXLEN); latch len_err = (req_len > MAXLEN); go to CLEAR.
- CLEAR (1 cycle):
  - dfa_rst = 1, dfa_in = 0.
  - Load the bit index with len-1.
  - Next state is SHIFT if len != 0, otherwise CHECK. Length 0 means the empty string: the verdict is the DFA start-state accept.
- SHIFT (len cycles):
  - dfa_in = latched bit[idx].
  - idx decrements each cycle.
  - After the cycle with idx == 0, go to CHECK.
- CHECK (1 cycle):
  - dfa_in = 0.
  - At the closing edge: res_accept <= dfa_accept; res_len_err <= len_err; res_valid <= 1.
  - tot_cnt++; acc_cnt++ if dfa_accept. Both counters saturate at all-ones.
  - Go to DONE.
- DONE:
  - res_valid, res_accept and res_len_err are held stable.
  - On res_ready: res_valid <= 0, go to IDLE.
  - res_ready low stalls indefinitely, with no loss of the result.
- Latency: res_valid rises len+2 edges after the request handshake edge (MAXLEN=16, len=4 gives 6). The next request can be accepted no earlier than one cycle after the result handshake.
- dfa_in = 0 in every state other than SHIFT.
- req_ready = 0 outside IDLE. Changes on req_bits/req_len after the handshake are ignored.
- rst asserted mid-SHIFT or mid-DONE:
  - Immediate return to reset values; any pending result is discarded.
  - Counters are cleared.
- res_accept is undefined-free: it holds its last value after res_valid falls and is only meaningful while res_valid = 1.

Test Plan (DUT connected to an ends-with-0 DFA, MAXLEN=16):
- Reset: rst low for 2 cycles, then high -> req_ready=1, res_valid=0, acc_cnt=tot_cnt=0, dfa_rst=1 while rst low.
- Accept: req_bits=0x000C, req_len=4 ("1100"), res_ready=1 -> dfa_in sequence 1,1,0,0 on consecutive cycles; res_valid rises 6 edges after the handshake; res_accept=1; acc_cnt=1, tot_cnt=1.
- Reject and back-to-back:
  - Send "1011" (0xB, len 4), then "100" (0x4, len 3), then "11" (0x3, len 2).
  - Required: res_accept = 0, 1, 0 in order; final acc_cnt=2, tot_cnt=4.
- Boundaries:
  - req_len=0 -> no SHIFT cycles; res_valid 2 edges after the handshake; res_accept=0.
  - req_len=20 -> 16 bits shifted; res_len_err=1.
- Backpressure: hold res_ready=0 for 10 cycles in DONE -> res_valid and res_accept stable, req_ready=0; result consumed on the first cycle res_ready=1.
- Mid-op reset: assert rst during the 2nd SHIFT cycle of a len-8 string -> state IDLE, counters 0, no res_valid. The next request "0" (len 1) returns res_accept=1.
